multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32 datapath (PC, IR, regfile, ALU, immediate generator).
//  - Sequences fetch/decode/execute/memory/writeback for OP, OP_IMM, LOAD, STORE and BRANCH (BEQ/BNE).
//  - Drives every datapath enable and mux select, and selects the immediate format (I/S/B).
//  - Handshakes with instruction and data memory.
//  - Counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 33 +++
 rtl/ctrl_opc_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Purpose : shared encodings for the RV32 multi-cycle controller, immediate generator and ALU.
// Latency : n/a (constants and types only).
// Backpressure: n/a.
// Contents: opcode values, FSM state encoding, ALU_OP_* and IMM_SEL_* codes.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_SEL_I = 2'b00;
  localparam logic [1:0] IMM_SEL_S = 2'b01;
  localparam logic [1:0] IMM_SEL_B = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

endpackage

// File: rtl/ctrl_opc_decode.sv
// Purpose : classify a 7-bit RV32 opcode into one of six instruction classes (one-hot).
// Latency : combinational.
// Backpressure: none.
// Ports   : i_opcode (instr[6:0]) -> o_is_op/o_is_imm/o_is_load/o_is_store/o_is_branch/o_is_illegal.
module ctrl_opc_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_is_op,
  output logic       o_is_imm,
  output logic       o_is_load,
  output logic       o_is_store,
  output logic       o_is_branch,
  output logic       o_is_illegal
);

  always_comb begin
    o_is_op      = 1'b0;
    o_is_imm     = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_is_branch  = 1'b0;
    o_is_illegal = 1'b0;
    case (i_opcode)
      OPC_OP:     o_is_op     = 1'b1;
      OPC_OP_IMM: o_is_imm    = 1'b1;
      OPC_LOAD:   o_is_load   = 1'b1;
      OPC_STORE:  o_is_store  = 1'b1;
      OPC_BRANCH: o_is_branch = 1'b1;
      default:    o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle control FSM for the RV32 datapath, plus retired-instruction counter.
// Latency : zero-wait memories: branch 3, OP/OP_IMM/STORE 4, LOAD 5 cycles per instruction.
// Backpressure: FETCH waits on i_imem_ready, MEM waits on i_dmem_ready, both without timeout.
// Ports   : i_clk, i_rst_n (async, active low), i_instr (IR), i_alu_zero, i_imem_ready, i_dmem_ready;
//           o_imem_req, o_dmem_req/o_dmem_we, datapath enables (ir/pc/tgt/reg), mux selects
//           (pc_src, alu_src_a/b, alu_op, imm_sel, wb_sel), o_busy, o_retire, o_retire_cnt.
// Config  : ILLEGAL_TRAP_EN adds o_trap; unknown opcodes then park the FSM in TRAP until reset.
//           Without it, unknown opcodes retire as NOPs.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_alu_zero,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_pc_src,
  output logic             o_tgt_we,
  output logic             o_alu_src_a,
  output logic             o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_imm_sel,
  output logic             o_reg_we,
  output logic             o_wb_sel,
  output logic             o_busy,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retire_cnt
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             o_trap
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_run;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_is_op, w_is_imm, w_is_load, w_is_store, w_is_branch, w_is_illegal;
  logic w_br_taken;
  logic w_unused;

  // Only opcode and funct3 steer the controller; funct7/registers belong to the datapath.
  assign w_unused = ^{i_instr[31:15], i_instr[11:7]};

  ctrl_opc_decode u_opc_decode (
    .i_opcode     (i_instr[6:0]),
    .o_is_op      (w_is_op),
    .o_is_imm     (w_is_imm),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_is_branch  (w_is_branch),
    .o_is_illegal (w_is_illegal)
  );

  assign w_br_taken = ((i_instr[14:12] == F3_BEQ) &&  i_alu_zero) ||
                      ((i_instr[14:12] == F3_BNE) && !i_alu_zero);

  // r_run is cleared asynchronously by reset and set on the first edge after release.
  // Gating every output with it keeps outputs at 0 while reset is asserted and makes
  // imem_req appear only once the controller is actually running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_state <= ST_FETCH;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_run) begin
      case (r_state)
        ST_FETCH:  if (i_imem_ready) w_state_nxt = ST_DECODE;
        ST_DECODE: w_state_nxt = ST_EXEC;
        ST_EXEC: begin
          if (w_is_op || w_is_imm)          w_state_nxt = ST_WB;
          else if (w_is_load || w_is_store) w_state_nxt = ST_MEM;
          else if (w_is_branch)             w_state_nxt = ST_FETCH;
          else begin
`ifdef ILLEGAL_TRAP_EN
            w_state_nxt = ST_TRAP;
`else
            w_state_nxt = ST_FETCH;
`endif
          end
        end
        ST_MEM:    if (i_dmem_ready) w_state_nxt = w_is_store ? ST_FETCH : ST_WB;
        ST_WB:     w_state_nxt = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP:   w_state_nxt = ST_TRAP;
`endif
        default:   w_state_nxt = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_src    = 1'b0;
    o_tgt_we    = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 1'b0;
    o_alu_op    = ALU_OP_ADD;
    o_imm_sel   = IMM_SEL_I;
    o_reg_we    = 1'b0;
    o_wb_sel    = 1'b0;
    o_busy      = 1'b0;
    o_retire    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    o_trap      = 1'b0;
`endif
    if (r_run) begin
      case (r_state)
        ST_FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            o_ir_we = 1'b1;
            o_pc_we = 1'b1;
          end
        end
        ST_DECODE: begin
          // old_pc + B-immediate is computed here for every instruction; only a
          // taken branch ever consumes the target register.
          o_busy      = 1'b1;
          o_alu_src_a = 1'b1;
          o_alu_src_b = 1'b1;
          o_imm_sel   = IMM_SEL_B;
          o_tgt_we    = 1'b1;
        end
        ST_EXEC: begin
          o_busy = 1'b1;
          if (w_is_op) begin
            o_alu_op = ALU_OP_FUNCT;
          end else if (w_is_imm) begin
            o_alu_src_b = 1'b1;
            o_alu_op    = ALU_OP_FUNCT;
          end else if (w_is_load) begin
            o_alu_src_b = 1'b1;
          end else if (w_is_store) begin
            o_alu_src_b = 1'b1;
            o_imm_sel   = IMM_SEL_S;
          end else if (w_is_branch) begin
            o_alu_op = ALU_OP_SUB;
            o_retire = 1'b1;
            if (w_br_taken) begin
              o_pc_we  = 1'b1;
              o_pc_src = 1'b1;
            end
          end else if (w_is_illegal) begin
`ifndef ILLEGAL_TRAP_EN
            o_retire = 1'b1;
`endif
          end
        end
        ST_MEM: begin
          // Address selects stay as in EXEC so the address is stable for the access.
          o_busy      = 1'b1;
          o_dmem_req  = 1'b1;
          o_dmem_we   = w_is_store;
          o_alu_src_b = 1'b1;
          o_imm_sel   = w_is_store ? IMM_SEL_S : IMM_SEL_I;
          o_retire    = i_dmem_ready && w_is_store;
        end
        ST_WB: begin
          o_busy   = 1'b1;
          o_reg_we = 1'b1;
          o_wb_sel = w_is_load;
          o_retire = 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP: begin
          o_busy = 1'b1;
          o_trap = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retire_cnt <= '0;
    end else if (o_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : directed self-checking bench for multicycle_ctrl (CNT_W=4 so the counter wrap is reachable).
// Latency : n/a.
// Backpressure: exercises imem/dmem wait states.
module tb_multicycle_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [31:0] i_instr;
  logic       i_alu_zero, i_imem_ready, i_dmem_ready;
  logic       o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we, o_pc_src, o_tgt_we;
  logic       o_alu_src_a, o_alu_src_b, o_reg_we, o_wb_sel, o_busy, o_retire;
  logic [1:0] o_alu_op, o_imm_sel;
  logic [3:0] o_retire_cnt;
  logic       w_trap;

  always #5 i_clk = ~i_clk;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_instr      (i_instr),
    .i_alu_zero   (i_alu_zero),
    .i_imem_ready (i_imem_ready),
    .i_dmem_ready (i_dmem_ready),
    .o_imem_req   (o_imem_req),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_ir_we      (o_ir_we),
    .o_pc_we      (o_pc_we),
    .o_pc_src     (o_pc_src),
    .o_tgt_we     (o_tgt_we),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_alu_op     (o_alu_op),
    .o_imm_sel    (o_imm_sel),
    .o_reg_we     (o_reg_we),
    .o_wb_sel     (o_wb_sel),
    .o_busy       (o_busy),
    .o_retire     (o_retire),
    .o_retire_cnt (o_retire_cnt)
`ifdef ILLEGAL_TRAP_EN
    ,
    .o_trap       (w_trap)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign w_trap = 1'b0;
`endif

  logic [16:0] w_ov;
  assign w_ov = {o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we, o_pc_src, o_tgt_we,
                 o_alu_src_a, o_alu_src_b, o_alu_op, o_imm_sel, o_reg_we, o_wb_sel,
                 o_busy, o_retire};

  int         total = 0;
  int         bad   = 0;
  logic [3:0] sb[$];
  logic [3:0] m_cnt;

  function automatic logic [16:0] ov(
    input logic imem, dreq, dwe, irwe, pcwe, pcsrc, tgt, sa, sb_, input logic [1:0] aop, isel,
    input logic rwe, wbs, bsy, ret);
    return {imem, dreq, dwe, irwe, pcwe, pcsrc, tgt, sa, sb_, aop, isel, rwe, wbs, bsy, ret};
  endfunction

  localparam logic [16:0] V_ZERO  = 17'd0;
  localparam logic [16:0] V_FWAIT = 17'h10000;  // imem_req only

  // Called at a negedge with inputs already driven; checks this cycle and moves to the next negedge.
  task automatic step(input string tag, input logic [16:0] exp, input logic texp);
    logic       ret;
    logic [3:0] want;
    want = 4'd0;
    #1;
    total++;
    assert ({texp, exp} === {w_trap, w_ov})
      else begin bad++; $error("FAIL %s obs=%h exp=%h", tag, {w_trap, w_ov}, {texp, exp}); end
    ret = o_retire;
    if (ret) begin
      total++;
      assert (sb.size() != 0)
        else begin bad++; $error("FAIL %s_sb obs=retire exp=no_retire", tag); end
      if (sb.size() != 0) want = sb.pop_front();
      else ret = 1'b0;
    end
    @(negedge i_clk);
    if (ret) begin
      total++;
      assert (o_retire_cnt === want)
        else begin bad++; $error("FAIL %s_cnt obs=%0d exp=%0d", tag, o_retire_cnt, want); end
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    total++;
    assert (o_retire_cnt === exp)
      else begin bad++; $error("FAIL %s obs=%0d exp=%0d", tag, o_retire_cnt, exp); end
  endtask

  // One instruction from FETCH to retire; expectations from the opcode and the bench's taken flag.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic zero,
                           input logic taken, input int iw, input int dw, input int exp_lat);
    logic [6:0]  opc;
    logic [16:0] ex;
    logic        is_ld, is_st, is_mem, is_wb;
    int          lat;
    opc    = ins[6:0];
    is_ld  = (opc == 7'b0000011);
    is_st  = (opc == 7'b0100011);
    is_mem = is_ld || is_st;
    is_wb  = is_ld || (opc == 7'b0110011) || (opc == 7'b0010011);
    lat    = 0;
    m_cnt  = m_cnt + 4'd1;
    sb.push_back(m_cnt);
    i_instr = ins;
    i_alu_zero = zero;
    for (int k = 0; k < iw; k++) begin
      i_imem_ready = 1'b0;
      step({tag, "_fwait"}, V_FWAIT, 1'b0);
      lat++;
    end
    i_imem_ready = 1'b1;
    step({tag, "_fetch"}, ov(1,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0), 1'b0);
    lat++;
    // Stray ready strobes in DECODE must be ignored.
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b1;
    step({tag, "_dec"}, ov(0,0,0,0,0,0,1,1,1,2'b00,2'b10,0,0,1,0), 1'b0);
    lat++;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    case (opc)
      7'b0110011: ex = ov(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,1,0);
      7'b0010011: ex = ov(0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,1,0);
      7'b0000011: ex = ov(0,0,0,0,0,0,0,0,1,2'b00,2'b00,0,0,1,0);
      7'b0100011: ex = ov(0,0,0,0,0,0,0,0,1,2'b00,2'b01,0,0,1,0);
      7'b1100011: ex = ov(0,0,0,0,taken,taken,0,0,0,2'b01,2'b00,0,0,1,1);
      default:    ex = ov(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,1);
    endcase
    step({tag, "_exec"}, ex, 1'b0);
    lat++;
    if (is_mem) begin
      for (int k = 0; k < dw; k++) begin
        step({tag, "_mwait"}, ov(0,1,is_st,0,0,0,0,0,1,2'b00,{1'b0,is_st},0,0,1,0), 1'b0);
        lat++;
      end
      i_dmem_ready = 1'b1;
      step({tag, "_mem"}, ov(0,1,is_st,0,0,0,0,0,1,2'b00,{1'b0,is_st},0,0,1,is_st), 1'b0);
      lat++;
      i_dmem_ready = 1'b0;
    end
    if (is_wb) begin
      step({tag, "_wb"}, ov(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1,is_ld,1,1), 1'b0);
      lat++;
    end
    total++;
    assert (lat == exp_lat)
      else begin bad++; $error("FAIL %s_lat obs=%0d exp=%0d", tag, lat, exp_lat); end
  endtask

  // Asserts reset between edges, checks outputs drop immediately, releases at a negedge.
  task automatic do_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    #1;
    total++;
    assert ({w_trap, w_ov} === 18'd0)
      else begin bad++; $error("FAIL %s_async obs=%h exp=0", tag, {w_trap, w_ov}); end
    chk_cnt({tag, "_cnt0"}, 4'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    sb.delete();
    m_cnt = 4'd0;
    step({tag, "_rel"}, V_ZERO, 1'b0);
    step({tag, "_first"}, V_FWAIT, 1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_instr = 32'h0;
    i_alu_zero = 1'b0;
    i_imem_ready = 1'b0;
    i_dmem_ready = 1'b0;
    m_cnt = 4'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    total++;
    assert ({w_trap, w_ov} === 18'd0)
      else begin bad++; $error("FAIL reset_out obs=%h exp=0", {w_trap, w_ov}); end
    chk_cnt("reset_cnt", 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step("rel_out", V_ZERO, 1'b0);

    run_instr("addi", 32'h00500093, 1'b0, 1'b0, 1, 0, 5);
    chk_cnt("addi_cnt1", 4'd1);
    run_instr("sw",   32'h00102223, 1'b0, 1'b0, 0, 3, 7);
    run_instr("lw",   32'h00002103, 1'b0, 1'b0, 0, 0, 5);
    run_instr("beq_t",  32'h00000463, 1'b1, 1'b1, 0, 0, 3);
    run_instr("beq_nt", 32'h00000463, 1'b0, 1'b0, 0, 0, 3);
    run_instr("bne_t",  32'h00001463, 1'b0, 1'b1, 0, 0, 3);
    run_instr("blt_nt", 32'h00004463, 1'b1, 1'b0, 0, 0, 3);
    run_instr("add",  32'h002081B3, 1'b0, 1'b0, 2, 0, 6);

`ifdef ILLEGAL_TRAP_EN
    i_instr = 32'h0000007F;
    i_imem_ready = 1'b1;
    step("ill_fetch", ov(1,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0), 1'b0);
    i_imem_ready = 1'b0;
    step("ill_dec", ov(0,0,0,0,0,0,1,1,1,2'b00,2'b10,0,0,1,0), 1'b0);
    step("ill_exec", ov(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0), 1'b0);
    for (int k = 0; k < 4; k++) begin
      i_imem_ready = 1'b1;
      i_dmem_ready = 1'b1;
      step("ill_trap", ov(0,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1,0), 1'b1);
    end
    chk_cnt("ill_cnt", 4'd8);
    do_reset("trap_rst");
`else
    run_instr("ill_nop", 32'h0000007F, 1'b0, 1'b0, 0, 0, 3);
    chk_cnt("nop_cnt", 4'd9);
    step("nop_fetch", V_FWAIT, 1'b0);
`endif

    // Reset while a load is waiting in MEM with dmem_req high.
    i_instr = 32'h00002103;
    i_imem_ready = 1'b1;
    step("rm_fetch", ov(1,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,0,0), 1'b0);
    i_imem_ready = 1'b0;
    step("rm_dec", ov(0,0,0,0,0,0,1,1,1,2'b00,2'b10,0,0,1,0), 1'b0);
    step("rm_exec", ov(0,0,0,0,0,0,0,0,1,2'b00,2'b00,0,0,1,0), 1'b0);
    step("rm_mem", ov(0,1,0,0,0,0,0,0,1,2'b00,2'b00,0,0,1,0), 1'b0);
    do_reset("mem_rst");

    // Counter wrap at CNT_W=4: 15 retires reach all-ones, the 16th wraps to 0.
    for (int k = 0; k < 15; k++) run_instr("wrap_addi", 32'h00500093, 1'b0, 1'b0, 0, 0, 4);
    chk_cnt("cnt_ones", 4'hF);
    run_instr("wrap_last", 32'h00500093, 1'b0, 1'b0, 0, 0, 4);
    chk_cnt("cnt_wrap", 4'h0);
    step("post_wrap_fetch", V_FWAIT, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
